// File: rtl/req_ack_responder.sv
// req_ack_responder: responder end of a single-bit req/ack handshake.
// Every cycle req is sampled high counts as one request. Each request is answered
// by ack within MIN_LAT..MAX_LAT edges. inject_miss suppresses an ack that is due.
// Optional feature macro: ACK_JITTER_EN. When defined, an LFSR picks the latency
// per request; otherwise the latency is fixed at MIN_LAT.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req                  request, sampled every posedge
//   inject_miss          suppresses the ack due at this edge
//   ack                  acknowledge (registered)
//   miss                 one-cycle pulse when a due ack was suppressed
//   pend_cnt             requests accepted whose ack/miss pulse has not yet finished
//   ack_cnt, miss_cnt    ack count (wraps), miss count (saturates)
module req_ack_responder #(
  parameter int         MIN_LAT   = 1,
  parameter int         MAX_LAT   = 3,
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int         CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req,
  input  logic                         inject_miss,
  output logic                         ack,
  output logic                         miss,
  output logic [$clog2(MAX_LAT+1)-1:0] pend_cnt,
  output logic [CNT_W-1:0]             ack_cnt,
  output logic [CNT_W-1:0]             miss_cnt
);
  localparam int PW = $clog2(MAX_LAT + 1);
  // bit k: ack register is set at the edge k edges after the next one
  logic [MAX_LAT-1:0] r_slot;
  logic [MAX_LAT-1:0] w_slot;
  logic [31:0]        w_lat;
  logic               w_placed;
  logic               w_due;
  logic               r_ack;
  logic               r_miss;
  logic [PW-1:0]      r_pend;
  logic [CNT_W-1:0]   r_ack_cnt;
  logic [CNT_W-1:0]   r_miss_cnt;
`ifdef ACK_JITTER_EN
  logic [7:0] r_lfsr;
  always_ff @(posedge clk)
    if (rst) r_lfsr <= LFSR_SEED;
    else if (req) r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_lat = MIN_LAT + 32'(r_lfsr) % (MAX_LAT - MIN_LAT + 1);
`else
  assign w_lat = MIN_LAT;
`endif
  // elaboration marker: a zero seed would lock the jitter LFSR at zero
  if (LFSR_SEED == 8'h00) begin : g_zero_seed_locks_lfsr
  end
  // new request takes the earliest free slot no sooner than its latency;
  // the top slot is always free, so a request is never dropped
  always_comb begin
    w_slot = r_slot;
    w_placed = 1'b0;
    for (int k = 0; k < MAX_LAT; k++)
      if (req && !w_placed && !r_slot[k] && 32'(k + 1) >= w_lat) begin
        w_slot[k] = 1'b1;
        w_placed = 1'b1;
      end
  end
  assign w_due = w_slot[0];
  always_ff @(posedge clk)
    if (rst) begin
      r_slot     <= '0;
      r_ack      <= 1'b0;
      r_miss     <= 1'b0;
      r_pend     <= '0;
      r_ack_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_slot     <= w_slot >> 1;
      r_ack      <= w_due & ~inject_miss;
      r_miss     <= w_due & inject_miss;
      r_pend     <= r_pend + PW'(req) - PW'(r_ack | r_miss);
      r_ack_cnt  <= r_ack_cnt + CNT_W'(w_due & ~inject_miss);
      r_miss_cnt <= r_miss_cnt + CNT_W'(w_due & inject_miss & ~&r_miss_cnt);
    end
  assign ack      = r_ack;
  assign miss     = r_miss;
  assign pend_cnt = r_pend;
  assign ack_cnt  = r_ack_cnt;
  assign miss_cnt = r_miss_cnt;
endmodule

// File: tb/tb_req_ack_responder.sv
// tb_req_ack_responder: random and directed checks of two responder configurations against a timeline model.
module tb_req_ack_responder;
  logic        clk = 1'b0;
  logic        rst, req, inject_miss;
  logic        ack0, miss0, ack1, miss1;
  logic [1:0]  pend0, pend1;
  logic [3:0]  acnt0, mcnt0;
  logic [15:0] acnt1, mcnt1;
  int n_err = 0;
  int n_chk = 0;
  int e = 0;
  bit busy[int];
  int x_ack[2], x_miss[2], x_pend[2], x_acnt[2], x_mcnt[2];
  req_ack_responder #(.MIN_LAT(1), .MAX_LAT(3), .CNT_W(4)) u0 (
    .clk(clk), .rst(rst), .req(req), .inject_miss(inject_miss),
    .ack(ack0), .miss(miss0), .pend_cnt(pend0), .ack_cnt(acnt0), .miss_cnt(mcnt0));
  req_ack_responder #(.MIN_LAT(3), .MAX_LAT(3), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .req(req), .inject_miss(inject_miss),
    .ack(ack1), .miss(miss1), .pend_cnt(pend1), .ack_cnt(acnt1), .miss_cnt(mcnt1));
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, e, act, exp);
    end
  endtask
  // timeline model: busy[key] marks the absolute edge at which ack is set
  task automatic model(input int n, input int lat, input int maxl, input int w,
                       input bit r, input bit inj, input bit rs);
    int key, t;
    bit due;
    key = n * 1000000;
    if (rs) begin
      busy.delete();
      x_ack[n] = 0; x_miss[n] = 0; x_pend[n] = 0; x_acnt[n] = 0; x_mcnt[n] = 0;
      return;
    end
    if (r) begin
      t = e + lat - 1;
      while (busy.exists(key + t)) t++;
      busy[key + t] = 1'b1;
    end
    due = busy.exists(key + e);
    if (due) busy.delete(key + e);
    x_ack[n] = int'(due && !inj);
    x_miss[n] = int'(due && inj);
    if (x_ack[n] == 1) x_acnt[n] = (x_acnt[n] + 1) % (1 << w);
    if (x_miss[n] == 1 && x_mcnt[n] < (1 << w) - 1) x_mcnt[n]++;
    x_pend[n] = x_ack[n] + x_miss[n];
    for (int k = 1; k <= maxl; k++) if (busy.exists(key + e + k)) x_pend[n]++;
  endtask
  task automatic cmp_all();
    check("ack0", int'(ack0), x_ack[0]);
    check("miss0", int'(miss0), x_miss[0]);
    check("pend0", int'(pend0), x_pend[0]);
    check("ack_cnt0", int'(acnt0), x_acnt[0]);
    check("miss_cnt0", int'(mcnt0), x_mcnt[0]);
    check("ack1", int'(ack1), x_ack[1]);
    check("miss1", int'(miss1), x_miss[1]);
    check("pend1", int'(pend1), x_pend[1]);
    check("ack_cnt1", int'(acnt1), x_acnt[1]);
    check("miss_cnt1", int'(mcnt1), x_mcnt[1]);
  endtask
  task automatic cyc(input bit r, input bit inj, input bit rs);
    req = r; inject_miss = inj; rst = rs;
    @(posedge clk);
    model(0, 1, 3, 4, r, inj, rs);
    model(1, 3, 3, 16, r, inj, rs);
    e++;
    #1;
    cmp_all();
    @(negedge clk);
  endtask
  initial begin
    bit t2_req[7] = '{1, 1, 1, 1, 0, 0, 0};
    int t2_ack[7] = '{0, 0, 1, 1, 1, 1, 0};
    int t2_pend[7] = '{1, 2, 3, 3, 2, 1, 0};
    rst = 1'b1; req = 1'b0; inject_miss = 1'b0;
    @(negedge clk);
    cyc(0, 0, 1); cyc(0, 0, 1);
    check("rst_ack0", int'(ack0), 0);
    check("rst_pend0", int'(pend0), 0);
    check("rst_ack_cnt1", int'(acnt1), 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    check("t1_ack0_set", int'(ack0), 1);
    check("t1_pend0_up", int'(pend0), 1);
    check("t1_pend1_up", int'(pend1), 1);
    cyc(0, 0, 0);
    check("t1_ack0_clr", int'(ack0), 0);
    check("t1_pend0_0", int'(pend0), 0);
    check("t1_ack_cnt0", int'(acnt0), 1);
    check("t1_ack1_early", int'(ack1), 0);
    cyc(0, 0, 0);
    check("t1_ack1_set", int'(ack1), 1);
    cyc(0, 0, 0);
    check("t1_ack1_clr", int'(ack1), 0);
    check("t1_pend1_0", int'(pend1), 0);
    check("t1_ack_cnt1", int'(acnt1), 1);
    for (int i = 0; i < 7; i++) begin
      cyc(t2_req[i], 0, 0);
      check("t2_ack1", int'(ack1), t2_ack[i]);
      check("t2_pend1", int'(pend1), t2_pend[i]);
    end
    cyc(0, 0, 1); cyc(0, 0, 0);
    cyc(1, 1, 0);
    check("t4_ack0", int'(ack0), 0);
    check("t4_miss0", int'(miss0), 1);
    check("t4_miss_cnt0", int'(mcnt0), 1);
    cyc(0, 0, 0);
    check("t4_miss0_clr", int'(miss0), 0);
    check("t4_pend0", int'(pend0), 0);
    cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 1);
    check("t5_ack0", int'(ack0), 0);
    check("t5_pend0", int'(pend0), 0);
    check("t5_ack_cnt0", int'(acnt0), 0);
    check("t5_pend1", int'(pend1), 0);
    check("t5_ack_cnt1", int'(acnt1), 0);
    cyc(1, 0, 0);
    check("t5_ack0_post", int'(ack0), 1);
    check("t5_ack1_stale", int'(ack1), 0);
    cyc(0, 0, 0);
    check("t5_ack1_wait", int'(ack1), 0);
    cyc(0, 0, 0);
    check("t5_ack1_post", int'(ack1), 1);
    check("t5_ack_cnt1", int'(acnt1), 1);
    cyc(0, 0, 1);
    for (int i = 0; i < 16; i++) cyc(1, 1, 0);
    check("t6_miss_sat", int'(mcnt0), 15);
    for (int i = 0; i < 16; i++) cyc(1, 0, 0);
    check("t6_ack_wrap", int'(acnt0), 0);
    check("t6_miss_hold", int'(mcnt0), 15);
    for (int i = 0; i < 1500; i++)
      cyc(1'($urandom % 2), $urandom_range(7) == 0, $urandom_range(199) == 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0);
    check("end_pend0", int'(pend0), 0);
    check("end_pend1", int'(pend1), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
